cache_assoc_controller: RTL and testbench
=========================================

Name: cache_assoc_controller

Overview:
Parametrised cache-controller FSM for a 1- or 2-way set-associative cache built from per-way tag/data arrays. It sits between the pipeline's memory stage and a pipelined banked main memory. It handles single-cycle hits, dirty-line writeback, multi-word line fill, victim-way selection and error reporting. Datapath muxing (addresses, data) is external; this block only drives the control lines.

Parameters:
NUM_WAYS, 2, number of ways (1 or 2); with 1, way 0 is always selected.
WORDS, 4, words per cache line (power of 2, >=2).
MEM_LAT, 2, cycles from mem_rd issue to read data valid (>=1); memory accepts one request per cycle.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rd  in  1  pipeline read request (sampled only in IDLE)
wr  in  1  pipeline write request (sampled only in IDLE)
hit  in  NUM_WAYS  per-way tag match (compare access)
valid  in  NUM_WAYS  per-way valid bit of indexed line
dirty  in  NUM_WAYS  per-way dirty bit of indexed line
cache_err  in  1  error from any cache array
mem_err  in  1  error from main memory
comp  out  1  cache compare mode (1 = tag compare, 0 = raw access)
cache_wr  out  1  cache write enable
way_sel  out  NUM_WAYS  one-hot way enable for the cache access
cache_off  out  $clog2(WORDS)  word offset for cache access
cache_valid_in  out  1  valid bit written on a fill write
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_off  out  $clog2(WORDS)  word offset for memory request
mem_tag_sel  out  1  1 = memory address uses victim's stored tag (writeback), 0 = request tag
stall  out  1  pipeline stall
done  out  1  request complete this cycle
cache_hit  out  1  request completed as a hit
err  out  1  error, valid only with done

Behaviour:
- Reset: state IDLE, counter 0, victim pointer 0, error flag 0; all outputs 0 except comp=1.
- States: IDLE, WB, FILL, FINAL.
- IDLE, no request: all outputs inactive.
- IDLE, rd&wr both high: done=1, err=1, no cache or memory access; stay IDLE.
- IDLE, single request: comp=1, cache_wr=wr, way_sel=all ways.
  - Hit = any (hit[i]&valid[i]): done=1, cache_hit=1, stall=0, way_sel=hitting way; stay IDLE (1-cycle hit).
  - Miss: stall=1, cache_wr qualified off; latch rd/wr and victim.
- Victim choice: lowest-index invalid way if one exists; otherwise the way given by the victim pointer. The pointer toggles on every miss where all ways were valid (NUM_WAYS=2 only).
- After a miss: next state WB if victim valid&dirty, else FILL. Counter is cleared.
- WB, WORDS cycles, counter 0..WORDS-1: comp=0, cache_wr=0, way_sel=victim, cache_off=mem_off=counter, mem_wr=1, mem_tag_sel=1. Then FILL, counter cleared.
- FILL, WORDS+MEM_LAT cycles, counter c=0..WORDS+MEM_LAT-1; way_sel=victim, comp=0 throughout.
  - mem_rd=1, mem_off=c while c<WORDS.
  - cache_wr=1, cache_valid_in=1, cache_off=c-MEM_LAT while c>=MEM_LAT.
  - Both may be active in the same cycle.
- FINAL, 1 cycle: comp=1, way_sel=victim, cache_wr=latched wr, done=1, cache_hit=0, stall=0; go to IDLE.
- stall=1 in every WB and FILL cycle and in the IDLE miss cycle.
- Errors: cache_err|mem_err in any non-IDLE cycle, or in the IDLE cycle of the request, sets a sticky flag. err = flag & done. Flag clears on return to IDLE. An error does not abort the sequence.
- rd/wr changes during a miss are ignored.
- Reset mid-operation: immediate return to IDLE with reset outputs; the partially filled line is left as written.
- Counter width: $clog2(WORDS+MEM_LAT); no wrap within a state.

Test Plan:
- Read hit on way1 (hit=2'b10, valid=2'b11) -> same cycle done=1, cache_hit=1, way_sel=2'b10, stall=0, no mem_rd.
- Read miss, valid=2'b00 (WORDS=4, MEM_LAT=2), request at cycle 0:
  - way_sel=2'b01.
  - mem_rd cycles 1-4, mem_off 0,1,2,3.
  - cache_wr cycles 3-6, cache_off 0,1,2,3, cache_valid_in=1.
  - done cycle 7 with cache_hit=0, err=0.
- Write miss, valid=2'b11, dirty=2'b10, victim pointer=1:
  - mem_wr cycles 1-4, mem_tag_sel=1, way_sel=2'b10.
  - fill cycles 5-10.
  - cycle 11: done=1, comp=1, cache_wr=1.
  - victim pointer becomes 0.
- mem_err pulsed in cycle 4 of a clean miss -> done still at cycle 7, err=1; next hit reports err=0.
- rd=wr=1 in IDLE -> done=1, err=1 same cycle; mem_rd=mem_wr=cache_wr=0.
- rst asserted in cycle 2 of WB -> outputs reset asynchronously, mem_wr=0; next request is handled normally from IDLE.

Source files
------------

// File: rtl/cache_assoc_controller_if.sv
// Control-side bundle between the pipeline memory stage, the cache arrays and
// main memory, as seen by cache_assoc_controller.
interface cache_assoc_controller_if #(
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned WORDS    = 4
);
  localparam int unsigned OFF_W = $clog2(WORDS);

  logic                rd;
  logic                wr;
  logic [NUM_WAYS-1:0] hit;
  logic [NUM_WAYS-1:0] valid;
  logic [NUM_WAYS-1:0] dirty;
  logic                cache_err;
  logic                mem_err;

  logic                comp;
  logic                cache_wr;
  logic [NUM_WAYS-1:0] way_sel;
  logic [OFF_W-1:0]    cache_off;
  logic                cache_valid_in;
  logic                mem_rd;
  logic                mem_wr;
  logic [OFF_W-1:0]    mem_off;
  logic                mem_tag_sel;
  logic                stall;
  logic                done;
  logic                cache_hit;
  logic                err;

  modport master (
    output rd, wr, hit, valid, dirty, cache_err, mem_err,
    input  comp, cache_wr, way_sel, cache_off, cache_valid_in, mem_rd, mem_wr,
           mem_off, mem_tag_sel, stall, done, cache_hit, err
  );

  modport slave (
    input  rd, wr, hit, valid, dirty, cache_err, mem_err,
    output comp, cache_wr, way_sel, cache_off, cache_valid_in, mem_rd, mem_wr,
           mem_off, mem_tag_sel, stall, done, cache_hit, err
  );
endinterface

// File: rtl/cache_assoc_controller.sv
// Control FSM for a 1/2-way set-associative cache: single-cycle hits,
// dirty-victim writeback, pipelined multi-word line fill and sticky error report.
module cache_assoc_controller #(
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned WORDS    = 4,
  parameter int unsigned MEM_LAT  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  cache_assoc_controller_if.slave  bus
);
  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned CNT_W = $clog2(WORDS + MEM_LAT);
  localparam logic [CNT_W-1:0] LAST_WB   = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(WORDS + MEM_LAT - 1);
  localparam logic [CNT_W-1:0] FIRST_WR  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] RD_END    = CNT_W'(WORDS);

  typedef enum logic [1:0] {IDLE, WB, FILL, FINAL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vptr_q, vptr_d;
  logic                err_q, err_d;
  logic                wr_q, wr_d;
  logic [NUM_WAYS-1:0] victim_q, victim_d;

  logic [NUM_WAYS-1:0] hv, hit_way, pick;
  logic                any_hit, all_valid, any_err, pick_dirty;

  // Lowest set bit isolation keeps way_sel one-hot for both hit and victim.
  always_comb begin
    hv         = bus.hit & bus.valid;
    any_hit    = |hv;
    hit_way    = hv & (~hv + NUM_WAYS'(1));
    all_valid  = &bus.valid;
    pick       = all_valid ? (NUM_WAYS'(1) << vptr_q)
                           : (~bus.valid & (bus.valid + NUM_WAYS'(1)));
    pick_dirty = |(pick & bus.valid & bus.dirty);
    any_err    = bus.cache_err | bus.mem_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vptr_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vptr_q   <= vptr_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      victim_q <= victim_d;
    end
  end

  // Outputs are gated by rst so an asserted reset shows reset values at once.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    vptr_d             = vptr_q;
    err_d              = err_q;
    wr_d               = wr_q;
    victim_d           = victim_q;
    bus.comp           = 1'b1;
    bus.cache_wr       = 1'b0;
    bus.way_sel        = '0;
    bus.cache_off      = '0;
    bus.cache_valid_in = 1'b0;
    bus.mem_rd         = 1'b0;
    bus.mem_wr         = 1'b0;
    bus.mem_off        = '0;
    bus.mem_tag_sel    = 1'b0;
    bus.stall          = 1'b0;
    bus.done           = 1'b0;
    bus.cache_hit      = 1'b0;
    bus.err            = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          err_d = 1'b0;
          if (bus.rd && bus.wr) begin
            bus.done = 1'b1;
            bus.err  = 1'b1;
          end else if (bus.rd || bus.wr) begin
            bus.way_sel  = '1;
            bus.cache_wr = bus.wr;
            if (any_hit) begin
              bus.done      = 1'b1;
              bus.cache_hit = 1'b1;
              bus.way_sel   = hit_way;
              bus.err       = any_err;
            end else begin
              bus.cache_wr = 1'b0;
              bus.stall    = 1'b1;
              wr_d         = bus.wr;
              victim_d     = pick;
              err_d        = any_err;
              cnt_d        = '0;
              if (all_valid && (NUM_WAYS > 1)) vptr_d = ~vptr_q;
              state_d      = pick_dirty ? WB : FILL;
            end
          end
        end

        WB: begin
          err_d           = err_q | any_err;
          bus.comp        = 1'b0;
          bus.stall       = 1'b1;
          bus.way_sel     = victim_q;
          bus.mem_wr      = 1'b1;
          bus.mem_tag_sel = 1'b1;
          bus.cache_off   = cnt_q[OFF_W-1:0];
          bus.mem_off     = cnt_q[OFF_W-1:0];
          if (cnt_q == LAST_WB) begin
            cnt_d   = '0;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        FILL: begin
          err_d       = err_q | any_err;
          bus.comp    = 1'b0;
          bus.stall   = 1'b1;
          bus.way_sel = victim_q;
          if (cnt_q < RD_END) begin
            bus.mem_rd  = 1'b1;
            bus.mem_off = cnt_q[OFF_W-1:0];
          end
          if (cnt_q >= FIRST_WR) begin
            bus.cache_wr       = 1'b1;
            bus.cache_valid_in = 1'b1;
            bus.cache_off      = OFF_W'(cnt_q - FIRST_WR);
          end
          if (cnt_q == LAST_FILL) begin
            cnt_d   = '0;
            state_d = FINAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        FINAL: begin
          bus.way_sel  = victim_q;
          bus.cache_wr = wr_q;
          bus.done     = 1'b1;
          bus.err      = err_q | any_err;
          err_d        = 1'b0;
          state_d      = IDLE;
        end

        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_assoc_controller.sv
// Self-checking bench for cache_assoc_controller: IDLE vector table plus
// scoreboarded multi-cycle miss, writeback, error and mid-operation reset cases.
module tb_cache_assoc_controller;
  localparam int unsigned NW  = 2;
  localparam int unsigned W   = 4;
  localparam int unsigned LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_assoc_controller_if #(.NUM_WAYS(NW), .WORDS(W)) bus ();

  cache_assoc_controller #(.NUM_WAYS(NW), .WORDS(W), .MEM_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic          done, cache_hit, err, stall, comp, cache_wr, cache_valid_in;
    logic          mem_rd, mem_wr, mem_tag_sel;
    logic [NW-1:0] way_sel;
    logic          chk_coff;
    logic [1:0]    cache_off;
    logic          chk_moff;
    logic [1:0]    mem_off;
  } exp_t;

  typedef struct {
    logic          rd, wr;
    logic [NW-1:0] hit, valid, dirty;
    logic          cerr, merr;
    exp_t          e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t zero_e();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e = zero_e();
    e.comp = 1'b1;
    return e;
  endfunction

  task automatic cmp(input string t, input exp_t e);
    chk({t, ".done"},      32'(bus.done),           32'(e.done));
    chk({t, ".cache_hit"}, 32'(bus.cache_hit),      32'(e.cache_hit));
    chk({t, ".err"},       32'(bus.err),            32'(e.err));
    chk({t, ".stall"},     32'(bus.stall),          32'(e.stall));
    chk({t, ".comp"},      32'(bus.comp),           32'(e.comp));
    chk({t, ".cache_wr"},  32'(bus.cache_wr),       32'(e.cache_wr));
    chk({t, ".valid_in"},  32'(bus.cache_valid_in), 32'(e.cache_valid_in));
    chk({t, ".mem_rd"},    32'(bus.mem_rd),         32'(e.mem_rd));
    chk({t, ".mem_wr"},    32'(bus.mem_wr),         32'(e.mem_wr));
    chk({t, ".tag_sel"},   32'(bus.mem_tag_sel),    32'(e.mem_tag_sel));
    chk({t, ".way_sel"},   32'(bus.way_sel),        32'(e.way_sel));
    if (e.chk_coff) chk({t, ".cache_off"}, 32'(bus.cache_off), 32'(e.cache_off));
    if (e.chk_moff) chk({t, ".mem_off"},   32'(bus.mem_off),   32'(e.mem_off));
  endtask

  // Expected per-cycle trace of a miss, from the IDLE miss cycle to FINAL.
  task automatic push_miss(input logic [NW-1:0] victim, input logic wb,
                           input logic wr, input logic experr);
    exp_t e;
    e = zero_e();
    e.comp = 1'b1; e.stall = 1'b1; e.way_sel = '1;
    sb.push_back(e);
    if (wb) begin
      for (int i = 0; i < int'(W); i++) begin
        e = zero_e();
        e.stall = 1'b1; e.way_sel = victim; e.mem_wr = 1'b1; e.mem_tag_sel = 1'b1;
        e.chk_coff = 1'b1; e.cache_off = 2'(i);
        e.chk_moff = 1'b1; e.mem_off = 2'(i);
        sb.push_back(e);
      end
    end
    for (int c = 0; c < int'(W + LAT); c++) begin
      e = zero_e();
      e.stall = 1'b1; e.way_sel = victim;
      if (c < int'(W)) begin
        e.mem_rd = 1'b1; e.chk_moff = 1'b1; e.mem_off = 2'(c);
      end
      if (c >= int'(LAT)) begin
        e.cache_wr = 1'b1; e.cache_valid_in = 1'b1;
        e.chk_coff = 1'b1; e.cache_off = 2'(c - int'(LAT));
      end
      sb.push_back(e);
    end
    e = zero_e();
    e.comp = 1'b1; e.way_sel = victim; e.cache_wr = wr; e.done = 1'b1; e.err = experr;
    sb.push_back(e);
  endtask

  // Drives the request in cycle 0, then rd=wr=1 noise that must be ignored.
  task automatic run_miss(input string t, input logic rd, input logic wr,
                          input logic [NW-1:0] valid, input logic [NW-1:0] dirty,
                          input int err_cycle);
    int   n;
    exp_t e;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.hit = '0; bus.valid = valid; bus.dirty = dirty;
      bus.rd = (k == 0) ? rd : 1'b1;
      bus.wr = (k == 0) ? wr : 1'b1;
      bus.mem_err = (k == err_cycle);
      #2;
      e = sb.pop_front();
      cmp($sformatf("%s[%0d]", t, k), e);
    end
    @(negedge clk);
    bus.rd = 1'b0; bus.wr = 1'b0; bus.mem_err = 1'b0;
  endtask

  task automatic apply_vec(input int i, input string t);
    @(negedge clk);
    bus.rd = vt[i].rd; bus.wr = vt[i].wr; bus.hit = vt[i].hit;
    bus.valid = vt[i].valid; bus.dirty = vt[i].dirty;
    bus.cache_err = vt[i].cerr; bus.mem_err = vt[i].merr;
    #2;
    cmp(t, vt[i].e);
    bus.rd = 1'b0; bus.wr = 1'b0; bus.cache_err = 1'b0; bus.mem_err = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.hit = '0; bus.valid = '0; bus.dirty = '0;
    bus.cache_err = 1'b0; bus.mem_err = 1'b0;

    // rd, wr, hit, valid, dirty, cerr, merr, expected
    vt[0] = '{1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 1'b0, 1'b0, idle_e()};
    e = idle_e(); e.done = 1'b1; e.cache_hit = 1'b1; e.way_sel = 2'b10;
    vt[1] = '{1'b1, 1'b0, 2'b10, 2'b11, 2'b00, 1'b0, 1'b0, e};
    e = idle_e(); e.done = 1'b1; e.cache_hit = 1'b1; e.way_sel = 2'b01;
    vt[2] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b0, e};
    e = idle_e(); e.done = 1'b1; e.cache_hit = 1'b1; e.way_sel = 2'b01; e.cache_wr = 1'b1;
    vt[3] = '{1'b0, 1'b1, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0, e};
    e = idle_e(); e.done = 1'b1; e.err = 1'b1;
    vt[4] = '{1'b1, 1'b1, 2'b10, 2'b11, 2'b11, 1'b0, 1'b0, e};
    e = idle_e(); e.done = 1'b1; e.cache_hit = 1'b1; e.err = 1'b1; e.way_sel = 2'b10;
    vt[5] = '{1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, e};

    #2;
    cmp("reset", idle_e());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) apply_vec(i, $sformatf("vec%0d", i));

    // Clean read miss into an empty set.
    push_miss(2'b01, 1'b0, 1'b0, 1'b0);
    run_miss("rmiss", 1'b1, 1'b0, 2'b00, 2'b00, -1);

    // mem_err mid-fill is reported at done and cleared afterwards.
    push_miss(2'b01, 1'b0, 1'b0, 1'b1);
    run_miss("errmiss", 1'b1, 1'b0, 2'b00, 2'b00, 4);
    apply_vec(1, "hit_after_err");

    // Invalid-but-dirty way 0 is preferred and needs no writeback.
    push_miss(2'b01, 1'b0, 1'b0, 1'b0);
    run_miss("inv0", 1'b1, 1'b0, 2'b10, 2'b11, -1);

    // All valid: pointer 0 picks way 0 and flips to 1.
    push_miss(2'b01, 1'b0, 1'b0, 1'b0);
    run_miss("ptr0", 1'b1, 1'b0, 2'b11, 2'b00, -1);

    // Pointer 1 picks dirty way 1: writeback, fill, write completes in FINAL.
    push_miss(2'b10, 1'b1, 1'b1, 1'b0);
    run_miss("wbmiss", 1'b0, 1'b1, 2'b11, 2'b10, -1);

    // Pointer back at 0: dirty way 0 starts a writeback, reset lands mid-WB.
    bus.hit = '0; bus.valid = 2'b11; bus.dirty = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.rd = (k == 0) ? 1'b0 : 1'b1;
      bus.wr = 1'b1;
      #2;
      chk($sformatf("rstwb[%0d].stall", k),  32'(bus.stall),  32'd1);
      chk($sformatf("rstwb[%0d].mem_wr", k), 32'(bus.mem_wr), (k == 0) ? 32'd0 : 32'd1);
      chk($sformatf("rstwb[%0d].way_sel", k), 32'(bus.way_sel), (k == 0) ? 32'd3 : 32'd1);
    end
    #1 rst = 1'b1;
    #1;
    cmp("rst_async", idle_e());
    @(negedge clk);
    bus.rd = 1'b0; bus.wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset cleared the pointer the aborted miss had flipped to 1.
    push_miss(2'b01, 1'b0, 1'b0, 1'b0);
    run_miss("postrst", 1'b1, 1'b0, 2'b11, 2'b00, -1);
    apply_vec(3, "hit_post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
